rho_unrotate: RTL and testbench
===============================

Name: rho_unrotate

Overview:
- Inverse of the rho lane-rotation step.
- Accepts one full Keccak state as 64 rotated 25-bit slices (slice z = 0..63), stores each bit at its un-rotated z, then streams out the 64 un-rotated slices.
- Sits on the decode/verification side of the matrix-encoder datapath, downstream of the slice-wise rotate stage.
- Both sides use valid/ready handshakes.

Parameters:
- LANE_W, 64, lane length in bits. Only 64 is supported; the offsets are taken mod 64.
- NLANES, 25, lanes per slice. Fixed.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_slice holds a valid rotated slice.
- in_ready  out  1  block accepts a slice this cycle.
- in_slice  in  25  rotated slice; bit i = lane i, where i = x+5y; bit 0 = lane (0,0).
- out_valid  out  1  out_slice valid.
- out_ready  in  1  consumer accepts out_slice.
- out_slice  out  25  un-rotated slice, same bit/lane mapping.
- out_z  out  6  z index of out_slice.
- out_last  out  1  high with out_valid when out_z = 63.
- busy  out  1  state is not LOAD, or cnt is not 0.

Behaviour:
- Reset (async assert on rst_n low, sync release):
  - state = LOAD, cnt = 0, buffer = all zero.
  - in_ready = 1, out_valid = 0, out_z = 0, out_last = 0, busy = 0.
- Offset table r[i], constant, indexed by i = x+5y, i = 0..24:
  - 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14.
- Storage: buffer[z][i], 64 x 25 flops, addressed in un-rotated z.
- LOAD state:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready, slice index is cnt. For every i: buffer[(cnt - r[i]) mod 64][i] <= in_slice[i].
  - The subtraction is 6-bit wrap-around; no sign handling.
  - All 25 lane writes of a slice happen in one cycle and target distinct (z, i) cells, so there are no conflicts.
  - cnt increments per accepted slice.
  - On acceptance with cnt = 63: cnt -> 0, state -> DRAIN.
- DRAIN state:
  - in_ready = 0, out_valid = 1.
  - out_slice = buffer[cnt], read combinationally from flops.
  - out_z = cnt; out_last = (cnt = 63).
  - On out_valid & out_ready: cnt increments.
  - On handshake with cnt = 63: cnt -> 0, state -> LOAD.
  - The first out_valid occurs the cycle after the 64th input handshake (1-cycle turnaround).
- Backpressure:
  - out_slice, out_z and out_last are held stable while out_valid & !out_ready.
  - in_valid while in DRAIN is ignored; in_ready = 0, so no write occurs.
- No simultaneous load and drain: one state frame at a time.
  - Throughput: 128 cycles per state at full handshake rate.
- Buffer is not cleared between frames. Every cell is overwritten exactly once per LOAD, because the mapping is a bijection per lane.
- Reset mid-LOAD or mid-DRAIN: immediate return to the reset values; any partial frame is discarded.
- The forward rotation is z_rot = (z + r[i]) mod 64; this block applies its exact inverse.

Decomposition:
- Shared package, also usable by the forward rotate stage:
  - constants NLANES = 25, LANE_W = 64;
  - RHO_OFFSET[0:24] (table above);
  - slice typedef logic [24:0];
  - state enum {LOAD, DRAIN}.
- One natural sub-module: rho_offset_rom.
  - Combinational; 5-bit lane index in, 6-bit offset out.
  - Instantiated 25x or replaced by a generate loop over constants.
- The rest (FSM, counter, 25 write-address subtractors, buffer, output mux) stays in rho_unrotate.

Test Plan:
- Lane 1 impulse: in_slice = 25'h0000002 at z = 0, all other slices 0 → draining gives out_slice = 25'h0000002 only at out_z = 63, zero elsewhere.
- Lane 2 impulse: bit 2 set at input z = 0 → output bit 2 set only at out_z = 2 (0 - 62 mod 64); lane 0 bit at z = 5 → out_z = 5.
- Round trip:
  - random 1600-bit state A, rotated by a software model, fed as 64 slices;
  - out_ready held 1 → 64 output slices equal A;
  - out_last asserted only on the 64th;
  - first out_valid is exactly 1 cycle after the last in handshake.
- Backpressure: out_ready toggles 1,0,0,1 pseudo-randomly → out_slice/out_z stable while stalled, no slice skipped or duplicated, in_ready = 0 throughout DRAIN.
- Reset mid-frame:
  - assert rst_n low after 30 inputs → in_ready = 1, out_valid = 0, cnt = 0 immediately;
  - a following full frame decodes correctly;
  - repeat the reset at drain slice 40.
- Two back-to-back frames with different data → the second output equals the second input un-rotated, with no residue from the first frame.

Source files
------------

// File: rtl/rho_unrotate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rho_unrotate_pkg
// Description : Shared rho constants, slice/state types and offset lookup.
// Revision    : 1.0
// ============================================================================
package rho_unrotate_pkg;

  localparam int NLANES = 25;
  localparam int LANE_W = 64;
  localparam int ZW     = 6;

  typedef logic [NLANES-1:0] slice_t;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Lane rotation offsets, indexed by i = x + 5y
  localparam logic [ZW-1:0] RHO_OFFSET [0:NLANES-1] = '{
    6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
    6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
    6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
    6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
    6'd18, 6'd2,  6'd61, 6'd56, 6'd14
  };

  function automatic logic [ZW-1:0] rho_offset(input logic [4:0] lane);
    logic [ZW-1:0] off;
    off = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (lane == 5'(k)) off = RHO_OFFSET[k];
    end
    return off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rho_unrotate_if.sv
`default_nettype none
// ============================================================================
// Module      : rho_unrotate_if
// Description : Slice-in / slice-out valid-ready bundle for rho_unrotate.
// Revision    : 1.0
// ============================================================================
interface rho_unrotate_if;
  import rho_unrotate_pkg::*;

  logic        in_valid;
  logic        in_ready;
  slice_t      in_slice;
  logic        out_valid;
  logic        out_ready;
  slice_t      out_slice;
  logic [5:0]  out_z;
  logic        out_last;

  modport slave (
    input  in_valid, in_slice, out_ready,
    output in_ready, out_valid, out_slice, out_z, out_last
  );

  modport master (
    output in_valid, in_slice, out_ready,
    input  in_ready, out_valid, out_slice, out_z, out_last
  );

endinterface
`default_nettype wire

// File: rtl/rho_unrotate_offset_rom.sv
`default_nettype none
// ============================================================================
// Module      : rho_offset_rom
// Description : Combinational lane index -> rho rotation offset lookup.
// Revision    : 1.0
// ============================================================================
module rho_offset_rom
  import rho_unrotate_pkg::*;
(
  input  logic [4:0]    lane,
  output logic [ZW-1:0] offset
);

  assign offset = rho_offset(lane);

endmodule
`default_nettype wire

// File: rtl/rho_unrotate.sv
`default_nettype none
// ============================================================================
// Module      : rho_unrotate
// Description : Collects 64 rotated slices, stores each bit at its un-rotated
//               z, then streams the 64 un-rotated slices back out.
// Revision    : 1.0
// ============================================================================
module rho_unrotate
  import rho_unrotate_pkg::ZW, rho_unrotate_pkg::slice_t,
         rho_unrotate_pkg::state_t, rho_unrotate_pkg::LOAD,
         rho_unrotate_pkg::DRAIN;
#(
  parameter int LANE_W = 64,
  parameter int NLANES = 25
)(
  input  logic          clk,
  input  logic          rst_n,
  rho_unrotate_if.slave bus,
  output logic          busy
);

  state_t        r_state;
  logic [ZW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_out_last;

  logic          w_load_fire;
  logic          w_drain_fire;
  slice_t        w_out_slice;

  assign w_load_fire  = bus.in_valid & r_in_ready;
  assign w_drain_fire = r_out_valid & bus.out_ready;

  // Storage kept lane-major: each lane is a 64-bit row addressed by un-rotated z
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    logic [ZW-1:0]     w_off;
    logic [ZW-1:0]     w_wr_z;
    logic [LANE_W-1:0] r_lane;

    rho_offset_rom u_rom (
      .lane   (5'(i)),
      .offset (w_off)
    );

    assign w_wr_z = r_cnt - w_off;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_lane <= '0;
      end else if (w_load_fire) begin
        r_lane[w_wr_z] <= bus.in_slice[i];
      end
    end

    assign w_out_slice[i] = r_lane[r_cnt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_load_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == ZW'(63)) begin
              r_state     <= DRAIN;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (w_drain_fire) begin
            r_cnt      <= r_cnt + 1'b1;
            r_out_last <= (r_cnt == ZW'(62));
            if (r_cnt == ZW'(63)) begin
              r_state     <= LOAD;
              r_in_ready  <= 1'b1;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= LOAD;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_slice = w_out_slice;
  assign bus.out_z     = r_cnt;
  assign bus.out_last  = r_out_last;
  assign busy          = (r_state != LOAD) || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_rho_unrotate.sv
`default_nettype none
// ============================================================================
// Module      : tb_rho_unrotate
// Description : Scoreboard bench for rho_unrotate using a forward-rho model.
// Revision    : 1.0
// ============================================================================
module tb_rho_unrotate;

  typedef logic [24:0] frame_t [0:63];

  localparam int c_rho [0:24] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10,
                                  43, 25, 39, 41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;
  logic [30:0] exp_q [$];

  rho_unrotate_if bus ();

  rho_unrotate #(.LANE_W(64), .NLANES(25)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Forward rho: bit of lane i at z lands at (z + r[i]) mod 64
  task automatic rotate(input frame_t a, output frame_t r);
    for (int z = 0; z < 64; z++) r[z] = '0;
    for (int z = 0; z < 64; z++)
      for (int i = 0; i < 25; i++)
        r[(z + c_rho[i]) % 64][i] = a[z][i];
  endtask

  task automatic rand_frame(output frame_t a);
    for (int z = 0; z < 64; z++) a[z] = 25'($urandom);
  endtask

  task automatic push_expected(input frame_t a);
    for (int z = 0; z < 64; z++) exp_q.push_back({6'(z), a[z]});
  endtask

  task automatic load(input frame_t rot, input int n);
    int k = 0;
    int guard = 0;
    while (k < n && guard < 1000) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_slice  = rot[k];
      bus.out_ready = 1'b0;
      check("load_out_valid", 64'(bus.out_valid), 64'd0);
      if (bus.in_ready) k++;
      @(posedge clk);
      guard++;
    end
    if (k < n) check("load_timeout", 64'(k), 64'(n));
  endtask

  task automatic drain(input int mode, input int nmax);
    int n = 0;
    int cyc = 0;
    logic [30:0] ex;
    while (exp_q.size() > 0 && n < nmax && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.in_valid  = 1'b1;
      bus.in_slice  = 25'($urandom);
      check((cyc == 1) ? "turnaround" : "drain_valid", 64'(bus.out_valid), 64'd1);
      if (bus.out_valid) begin
        ex = exp_q[0];
        check("out_z", 64'(bus.out_z), 64'(ex[30:25]));
        check("out_slice", 64'(bus.out_slice), 64'(ex[24:0]));
        check("out_last", 64'(bus.out_last), 64'(ex[30:25] == 6'd63));
        check("in_ready_drain", 64'(bus.in_ready), 64'd0);
        check("busy_drain", 64'(busy), 64'd1);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          n++;
        end
      end
      @(posedge clk);
    end
    if (cyc >= 2000) check("drain_timeout", 64'(n), 64'(nmax));
  endtask

  task automatic run_frame(input frame_t a, input frame_t rot, input int mode);
    push_expected(a);
    load(rot, 64);
    drain(mode, 64);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("idle_in_ready", 64'(bus.in_ready), 64'd1);
    check("idle_out_valid", 64'(bus.out_valid), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_z", 64'(bus.out_z), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    frame_t a, b, rot;
    bus.in_valid  = 1'b0;
    bus.in_slice  = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Lane 1 impulse at rotated z=0 -> un-rotated z=63
    for (int z = 0; z < 64; z++) begin a[z] = '0; rot[z] = '0; end
    rot[0] = 25'h0000002;
    a[63]  = 25'h0000002;
    run_frame(a, rot, 0);

    // Lane 2 at z=0 -> z=2; lane 0 at z=5 -> z=5
    for (int z = 0; z < 64; z++) begin a[z] = '0; rot[z] = '0; end
    rot[0] = 25'h0000004;
    rot[5] = 25'h0000001;
    a[2]   = 25'h0000004;
    a[5]   = 25'h0000001;
    run_frame(a, rot, 0);

    rand_frame(a); rotate(a, rot); run_frame(a, rot, 0);
    rand_frame(a); rotate(a, rot); run_frame(a, rot, 1);

    // Reset after 30 inputs, then a clean frame
    rand_frame(a); rotate(a, rot);
    load(rot, 30);
    do_reset();
    rand_frame(a); rotate(a, rot); run_frame(a, rot, 1);

    // Reset at drain slice 40, then a clean frame
    rand_frame(a); rotate(a, rot);
    push_expected(a);
    load(rot, 64);
    drain(0, 40);
    do_reset();
    rand_frame(a); rotate(a, rot); run_frame(a, rot, 0);

    // Back-to-back frames with different data
    rand_frame(a); rotate(a, rot); run_frame(a, rot, 0);
    rand_frame(b); rotate(b, rot); run_frame(b, rot, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
